traffic_request_conditioner: RTL and testbench



---
 rtl/traffic_pkg.sv | 7 +
 rtl/input_debouncer.sv | 29 ++
 rtl/traffic_request_conditioner.sv | 69 ++++++
 tb/tb_traffic_request_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light encodings, direction indices and debounce default
package traffic_pkg;
  typedef enum logic [2:0] {RED = 3'b001, YELLOW = 3'b010, GREEN = 3'b100} light_t;
  localparam int DIR_NS = 0;
  localparam int DIR_EW = 1;
  localparam int DEBOUNCE_DEFAULT = 8;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-flop synchroniser followed by a stable-count debouncer
module input_debouncer import traffic_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= s2;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner: debounced sensors/night level and latched ped requests
// Optional request-age counters are built when TRAFFIC_PED_WAIT_EN is defined.
module traffic_request_conditioner import traffic_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_sensor_NS,
  input  logic              raw_sensor_EW,
  input  logic              raw_ped_NS,
  input  logic              raw_ped_EW,
  input  logic              raw_night,
  input  logic              ped_ack_NS,
  input  logic              ped_ack_EW,
  output logic              sensor_NS,
  output logic              sensor_EW,
  output logic              ped_NS,
  output logic              ped_EW,
  output logic              night_mode,
  output logic [WAIT_W-1:0] ped_wait_NS,
  output logic [WAIT_W-1:0] ped_wait_EW
);
  logic [4:0] raw, lvl;
  logic [1:0] ped_lvl, ped_prev, ack, ack_prev, press, ack_fall, req, req_n;
  assign raw = {raw_night, raw_ped_EW, raw_ped_NS, raw_sensor_EW, raw_sensor_NS};
  for (genvar i = 0; i < 5; i++) begin : g_db
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(raw[i]), .level(lvl[i])
    );
  end
  assign sensor_NS = lvl[0];
  assign sensor_EW = lvl[1];
  assign night_mode = lvl[4];
  assign ped_lvl = lvl[3:2];
  assign ack = {ped_ack_EW, ped_ack_NS};
  // Clear on the falling edge of the walk so the controller's walk is not cut short
  always_comb begin
    press = ped_lvl & ~ped_prev;
    ack_fall = ack_prev & ~ack;
    req_n = (press & ~ack) | (req & ~ack_fall);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ped_prev <= '0;
      ack_prev <= '0;
      req <= '0;
    end else begin
      ped_prev <= ped_lvl;
      ack_prev <= ack;
      req <= req_n;
    end
  assign ped_NS = req[DIR_NS];
  assign ped_EW = req[DIR_EW];
`ifdef TRAFFIC_PED_WAIT_EN
  logic [1:0][WAIT_W-1:0] wait_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) wait_cnt <= '0;
    else
      for (int d = 0; d < 2; d++)
        if (req_n[d] && !req[d]) wait_cnt[d] <= '0;
        else if (req[d] && !(&wait_cnt[d])) wait_cnt[d] <= wait_cnt[d] + WAIT_W'(1);
  assign ped_wait_NS = wait_cnt[DIR_NS];
  assign ped_wait_EW = wait_cnt[DIR_EW];
`else
  assign ped_wait_NS = '0;
  assign ped_wait_EW = '0;
`endif
endmodule

// File: tb/tb_traffic_request_conditioner.sv
// tb_traffic_request_conditioner: table-driven plus sequence checks with a scoreboard queue
module tb_traffic_request_conditioner;
  logic clk = 1'b0, rst = 1'b0;
  logic raw_sensor_NS = 0, raw_sensor_EW = 0, raw_ped_NS = 0, raw_ped_EW = 0, raw_night = 0;
  logic ped_ack_NS = 0, ped_ack_EW = 0;
  logic sensor_NS, sensor_EW, ped_NS, ped_EW, night_mode;
  logic [7:0] ped_wait_NS, ped_wait_EW;
`ifdef TRAFFIC_PED_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  traffic_request_conditioner #(.DEBOUNCE_CYCLES(8), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .raw_sensor_NS(raw_sensor_NS), .raw_sensor_EW(raw_sensor_EW),
    .raw_ped_NS(raw_ped_NS), .raw_ped_EW(raw_ped_EW), .raw_night(raw_night),
    .ped_ack_NS(ped_ack_NS), .ped_ack_EW(ped_ack_EW),
    .sensor_NS(sensor_NS), .sensor_EW(sensor_EW), .ped_NS(ped_NS), .ped_EW(ped_EW),
    .night_mode(night_mode), .ped_wait_NS(ped_wait_NS), .ped_wait_EW(ped_wait_EW)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  typedef struct {logic sns; logic sew; logic night; int hold; logic [2:0] exp;} vec_t;
  typedef struct {string nm; logic [2:0] exp;} sb_t;
  vec_t tbl[6];
  sb_t q[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_sns"}, 32'(sensor_NS), 0);
    chk({nm, "_sew"}, 32'(sensor_EW), 0);
    chk({nm, "_pns"}, 32'(ped_NS), 0);
    chk({nm, "_pew"}, 32'(ped_EW), 0);
    chk({nm, "_night"}, 32'(night_mode), 0);
    chk({nm, "_wns"}, 32'(ped_wait_NS), 0);
    chk({nm, "_wew"}, 32'(ped_wait_EW), 0);
  endtask
  initial begin
    logic bad, ok;
    sb_t s;
    tbl[0] = '{1, 1, 0, 12, 3'b011};
    tbl[1] = '{0, 1, 1, 12, 3'b110};
    tbl[2] = '{1, 0, 0, 5, 3'b110};
    tbl[3] = '{0, 1, 1, 12, 3'b110};
    tbl[4] = '{1, 1, 1, 12, 3'b111};
    tbl[5] = '{0, 0, 0, 12, 3'b000};
    rst = 1'b1;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(2);
    raw_sensor_NS = 1;
    tick(9);
    chk("sns_edge9", 32'(sensor_NS), 0);
    tick(1);
    chk("sns_edge10", 32'(sensor_NS), 1);
    chk("sew_quiet", 32'(sensor_EW), 0);
    for (int i = 0; i < 6; i++) begin
      raw_sensor_NS = tbl[i].sns;
      raw_sensor_EW = tbl[i].sew;
      raw_night = tbl[i].night;
      q.push_back('{$sformatf("vec%0d", i), tbl[i].exp});
      tick(tbl[i].hold);
      s = q.pop_front();
      chk(s.nm, 32'({night_mode, sensor_EW, sensor_NS}), 32'(s.exp));
    end
    raw_ped_EW = 1;
    tick(5);
    raw_ped_EW = 0;
    bad = 0;
    repeat (20) begin
      tick(1);
      bad |= ped_EW;
    end
    chk("pew_glitch", 32'(bad), 0);
    raw_ped_NS = 1;
    tick(10);
    chk("pns_edge10", 32'(ped_NS), 0);
    tick(1);
    chk("pns_edge11", 32'(ped_NS), 1);
    ped_ack_NS = 1;
    ok = 1;
    repeat (30) begin
      tick(1);
      ok &= ped_NS;
    end
    chk("pns_hold_ack", 32'(ok), 1);
    ped_ack_NS = 0;
    tick(1);
    chk("pns_ack_fall", 32'(ped_NS), 0);
    tick(12);
    chk("pns_no_rerequest", 32'(ped_NS), 0);
    raw_ped_NS = 0;
    tick(15);
    raw_ped_NS = 1;
    tick(11);
    chk("pns_req2", 32'(ped_NS), 1);
    ped_ack_NS = 1;
    raw_ped_NS = 0;
    tick(15);
    raw_ped_NS = 1;
    tick(10);
    ped_ack_NS = 0;
    tick(1);
    chk("pns_set_wins", 32'(ped_NS), 1);
    tick(3);
    chk("pns_set_wins_hold", 32'(ped_NS), 1);
    ped_ack_NS = 1;
    tick(2);
    ped_ack_NS = 0;
    tick(1);
    chk("pns_clear2", 32'(ped_NS), 0);
    raw_ped_NS = 0;
    tick(15);
    ped_ack_EW = 1;
    tick(3);
    ped_ack_EW = 0;
    tick(2);
    chk("pew_stray_ack", 32'(ped_EW), 0);
    raw_sensor_NS = 1;
    raw_ped_NS = 1;
    tick(12);
    chk("pre_rst_sns", 32'(sensor_NS), 1);
    chk("pre_rst_pns", 32'(ped_NS), 1);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick(2);
    rst = 1'b0;
    tick(9);
    chk("post_rst_edge9", 32'(sensor_NS), 0);
    tick(1);
    chk("post_rst_edge10", 32'(sensor_NS), 1);
    tick(1);
    chk("post_rst_pns", 32'(ped_NS), 1);
    raw_ped_EW = 1;
    tick(10);
    chk("pew_edge10", 32'(ped_EW), 0);
    tick(1);
    chk("pew_edge11", 32'(ped_EW), 1);
    chk("wew_start", 32'(ped_wait_EW), 0);
    tick(1);
    chk("wew_one", 32'(ped_wait_EW), WEN ? 1 : 0);
    tick(300);
    chk("wew_sat", 32'(ped_wait_EW), WEN ? 255 : 0);
    ped_ack_EW = 1;
    tick(2);
    ped_ack_EW = 0;
    tick(1);
    chk("pew_cleared", 32'(ped_EW), 0);
    chk("wew_hold", 32'(ped_wait_EW), WEN ? 255 : 0);
    tick(5);
    chk("wew_hold2", 32'(ped_wait_EW), WEN ? 255 : 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
